// File: rtl/route_read_ctrl.sv
// route_read_ctrl: waits for a full row in the route read FIFO, then drains it under a
// 2-word credit into a valid/ready output buffer. Define ROUTE_RD_LAST_EN to add out_last.
module route_read_ctrl #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   row_words,
    input  logic [15:0]          row_num,
    output logic [ADDR_BITS:0]   m_count,
    input  logic                 fifo_ready,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef ROUTE_RD_LAST_EN
    output logic                 out_last,
`endif
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_WAIT, ST_READ, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic               settle_q, settle_d;
    logic [ADDR_BITS:0] words_q, words_d;
    logic [ADDR_BITS:0] rd_left_q, rd_left_d;
    logic [15:0]        rows_q, rows_d;
    logic [15:0]        row_cnt_q, row_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               inflight_q, inflight_d;
    logic [WIDTH-1:0]   mem_q [2];
    logic [WIDTH-1:0]   mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         occ_q, occ_d;

    logic               pop;
    logic               rd_en;
    logic               has_credit;
    logic               last_accept;
    logic [ADDR_BITS:0] row_words_eff;

    assign row_words_eff = (row_words == '0) ? (ADDR_BITS+1)'(1) : row_words;
    assign out_valid     = (occ_q != 2'd0);
    assign out_data      = mem_q[rd_ptr_q];
    assign pop           = out_valid && out_ready;
    // Same-cycle pop frees a slot, which is what sustains one word per cycle.
    assign has_credit    = (({1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
    assign rd_en         = (state_q == ST_READ) && (rd_left_q != '0) && has_credit;
    assign fifo_rd_en    = rd_en;
    assign m_count       = words_q;
    assign busy          = busy_q && !last_accept;
    assign done          = done_q || last_accept;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        words_d     = words_q;
        rows_d      = rows_q;
        row_cnt_d   = row_cnt_q;
        rd_left_d   = rd_left_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        last_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    words_d   = row_words_eff;
                    rows_d    = row_num;
                    row_cnt_d = '0;
                    if (row_num == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q) state_d = ST_WAIT;
                else          settle_d = 1'b1;
            end
            ST_WAIT: begin
                if (fifo_ready) begin
                    state_d   = ST_READ;
                    rd_left_d = words_q;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    rd_left_d = rd_left_q - (ADDR_BITS+1)'(1);
                    if (rd_left_q == (ADDR_BITS+1)'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Nothing in flight and one word left: this pop completes the row.
                if (!inflight_q && pop && (occ_q == 2'd1)) begin
                    row_cnt_d = row_cnt_q + 16'd1;
                    if ((row_cnt_q + 16'd1) == rows_q) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        last_accept = 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (inflight_q) mem_d[wr_ptr_q] = fifo_dout;
        wr_ptr_d   = wr_ptr_q ^ inflight_q;
        rd_ptr_d   = rd_ptr_q ^ pop;
        occ_d      = occ_q + 2'(inflight_q) - 2'(pop);
        inflight_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            settle_q   <= 1'b0;
            words_q    <= '0;
            rows_q     <= '0;
            row_cnt_q  <= '0;
            rd_left_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            words_q    <= words_d;
            rows_q     <= rows_d;
            row_cnt_q  <= row_cnt_d;
            rd_left_q  <= rd_left_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

`ifdef ROUTE_RD_LAST_EN
    logic last_mem_q [2];
    logic last_mem_d [2];
    logic last_fl_q, last_fl_d;

    assign out_last = out_valid && last_mem_q[rd_ptr_q];

    always_comb begin
        last_mem_d = last_mem_q;
        if (inflight_q) last_mem_d[wr_ptr_q] = last_fl_q;
        last_fl_d = rd_en && (rd_left_q == (ADDR_BITS+1)'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem_q <= '{default: 1'b0};
            last_fl_q  <= 1'b0;
        end else begin
            last_mem_q <= last_mem_d;
            last_fl_q  <= last_fl_d;
        end
    end
`endif

endmodule

// File: tb/tb_route_read_ctrl.sv
// tb_route_read_ctrl: scoreboard bench for route_read_ctrl with a behavioural FIFO
// (1-cycle read latency, M_Ready lagging data_count by 2 cycles).
module tb_route_read_ctrl;
    localparam int unsigned WIDTH     = 128;
    localparam int unsigned ADDR_BITS = 10;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             l;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_BITS:0]   row_words;
    logic [15:0]          row_num;
    logic [ADDR_BITS:0]   m_count;
    logic                 fifo_ready;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     fifo_dout;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rd_cnt, acc_cnt, done_cnt, first_rd_cyc, last_acc_cyc, start_cyc, raise_cyc;
    int   row_w   = 1;
    bit   chk_gap = 0;
    bit   sb_off  = 0;
    bit   zero_job = 0;
    bit   prev_stall = 0;
    logic [WIDTH-1:0] prev_data;
    logic [3:0] bp_pat = 4'b1001;
    logic mon_acc;
    exp_t mon_e;
    exp_t exp_q[$];

    logic [WIDTH-1:0] fifo_q[$];
    logic rdy1, rdy2, ready_en;

    route_read_ctrl #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_words  (row_words),
        .row_num    (row_num),
        .m_count    (m_count),
        .fifo_ready (fifo_ready),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef ROUTE_RD_LAST_EN
        .out_last   (out_last),
`endif
        .busy       (busy),
        .done       (done)
    );

`ifndef ROUTE_RD_LAST_EN
    assign out_last = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            rdy1      <= 1'b0;
            rdy2      <= 1'b0;
            fifo_dout <= '0;
        end else begin
            rdy1 <= (fifo_q.size() >= int'(m_count));
            rdy2 <= rdy1;
            if (fifo_rd_en && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        end
    end
    assign fifo_ready = rdy2 && ready_en;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            mon_acc = out_valid && out_ready;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (fifo_rd_en) begin
                check("rd_nonempty", fifo_q.size() != 0, 1);
                rd_cnt++;
                if (rd_cnt == 1) first_rd_cyc = cyc;
            end
            if (mon_acc) begin
                if (chk_gap && (acc_cnt % row_w) != 0) check("row_gap", cyc - last_acc_cyc, 1);
                last_acc_cyc = cyc;
                acc_cnt++;
                if (!sb_off) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("data", out_data, mon_e.d);
`ifdef ROUTE_RD_LAST_EN
                        check("last", out_last, mon_e.l);
`endif
                    end
                end
            end
            if (fifo_rd_en) check("outstanding_le2", (rd_cnt - acc_cnt) <= 2, 1);
            if (done) begin
                done_cnt++;
                if (!zero_job) check("done_on_last", {mon_acc, exp_q.size() == 0}, 2'b11);
            end
        end
    end

    task automatic preload(input int base, input int n, input int rw, input bit to_sb);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(WIDTH'(base + i));
            if (to_sb) begin
                e.d = WIDTH'(base + i);
                e.l = ((i % rw) == rw - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic kick(input int rw, input int rn);
        @(posedge clk); #1;
        row_words = (ADDR_BITS+1)'(rw);
        row_num   = 16'(rn);
        start     = 1'b1;
        rd_cnt    = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        first_rd_cyc = -1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit bp);
        bit got = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            if (bp) out_ready = bp_pat[i % 4];
            @(negedge clk);
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        check("done_seen", got, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; row_words = '0; row_num = '0;
        out_ready = 1'b1; ready_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mcount", m_count, 0);
        check("rst_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two rows of four, continuous drain.
        preload(0, 8, 4, 1);
        row_w = 4; chk_gap = 1;
        kick(4, 2);
        check("mcount", m_count, 4);
        wait_done(200, 0);
        chk_gap = 0;
        check("t1_first_rd", first_rd_cyc - start_cyc, 4);
        check("t1_reads", rd_cnt, 8);
        check("t1_accepts", acc_cnt, 8);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_busy_end", busy, 0);

        // fifo_ready held low while in WAIT.
        preload(300, 4, 4, 1);
        ready_en = 1'b0;
        kick(4, 1);
        repeat (20) @(posedge clk);
        #1;
        check("t2_no_reads", rd_cnt, 0);
        check("t2_busy", busy, 1);
        ready_en = 1'b1;
        raise_cyc = cyc;
        wait_done(100, 0);
        check("t2_first_rd", first_rd_cyc - raise_cyc, 1);
        check("t2_reads", rd_cnt, 4);
        check("t2_sb_empty", exp_q.size(), 0);

        // Backpressure 1,0,0,1.
        preload(100, 6, 6, 1);
        kick(6, 1);
        wait_done(200, 1);
        check("t3_reads", rd_cnt, 6);
        check("t3_accepts", acc_cnt, 6);
        check("t3_sb_empty", exp_q.size(), 0);

        // Zero-row job.
        zero_job = 1;
        kick(4, 0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_done_once", done, 0);
        check("t4_busy2", busy, 0);
        check("t4_reads", rd_cnt, 0);
        zero_job = 0;

        // row_words=0 behaves as one word.
        preload(900, 1, 1, 1);
        kick(0, 1);
        check("t5_mcount", m_count, 1);
        wait_done(100, 0);
        check("t5_reads", rd_cnt, 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset in the middle of READ.
        sb_off = 1;
        preload(500, 8, 8, 0);
        kick(8, 1);
        for (int i = 0; i < 50 && rd_cnt < 3; i++) begin
            @(negedge clk); #1;
        end
        check("t6_reads_seen", rd_cnt >= 3, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        sb_off = 0;
        preload(200, 2, 2, 1);
        kick(2, 1);
        wait_done(100, 0);
        check("t6_reads", rd_cnt, 2);
        check("t6_sb_empty", exp_q.size(), 0);
        check("t6_done_cnt", done_cnt, 1);

`ifdef ROUTE_RD_LAST_EN
        preload(700, 6, 3, 1);
        kick(3, 2);
        wait_done(200, 0);
        check("t7_reads", rd_cnt, 6);
        check("t7_sb_empty", exp_q.size(), 0);
        check("t7_last_idle", out_last, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/route_read_ctrl.md
# route_read_ctrl

Row-granular read controller that sits directly downstream of the route read FIFO in the TJPU route/concat path. It waits until the FIFO reports that a full row of feature words is buffered, then drains exactly that row with a credit-limited read stream. Each word is delivered through a 2-entry output buffer under a valid/ready handshake to the concat/write-back stage, and the cycle repeats for a programmed number of rows.

## Interface
- WIDTH, 128, feature word width; matches FIFO data width
- ADDR_BITS, 10, FIFO depth exponent; count ports are ADDR_BITS+1 wide
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, accepted only in IDLE
- row_words  in  ADDR_BITS+1  words per row, sampled at start; 0 treated as 1
- row_num  in  16  rows per job, sampled at start; 0 means done immediately
- m_count  out  ADDR_BITS+1  threshold driven to the FIFO's M_count; equals latched row_words
- fifo_ready  in  1  FIFO M_Ready (registered, data_count >= m_count)
- fifo_rd_en  out  1  FIFO read strobe
- fifo_dout  in  WIDTH  FIFO read data, valid one cycle after fifo_rd_en
- out_data  out  WIDTH  head of output buffer
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when last word of last row is accepted

## Operation
- States: IDLE, SETTLE, WAIT, READ, DRAIN.
- IDLE: on start, latch row_words/row_num, clear row counter. If row_num==0, pulse done next cycle and stay in IDLE; otherwise go to SETTLE.
- SETTLE: hold 2 cycles, ignoring fifo_ready (M_Ready lags data_count by 2 cycles after reads/threshold change), then go to WAIT.
- WAIT: when fifo_ready==1, go to READ and load rd_left=row_words.
- READ: assert fifo_rd_en when rd_left>0 and credit>0. Credit = 2 − (buffer occupancy + reads in flight). Each read decrements rd_left. When rd_left reaches 0, go to DRAIN.
- DRAIN: wait until every word of the row has been accepted downstream, then increment the row counter. Go to DONE handling if the counter equals row_num, else go to SETTLE.
- Last row: done pulses on the acceptance cycle of the final word; busy drops the same cycle; the FSM returns to IDLE.
- Output buffer: 2-entry FIFO. Push on the cycle after fifo_rd_en; pop on out_valid&&out_ready. Simultaneous push and pop keep occupancy unchanged.
- Never read the FIFO outside READ; never read more than row_words per row.
- start while busy is ignored.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_data=0, busy=0, done=0, m_count=0, state=IDLE, buffer empty.
- Start to first fifo_rd_en: at least 4 cycles (latch, 2 SETTLE, WAIT sample with fifo_ready=1).
- fifo_rd_en to out_valid: 2 cycles (FIFO latency plus buffer register).
- Throughput: 1 word/cycle sustained with out_ready held high.
- out_data is stable while out_valid=1 and out_ready=0.
- rst mid-job: all state is cleared in the same cycle. In-flight FIFO data is discarded. The FIFO itself is reset by the same rst.

## Configuration
- ROUTE_RD_LAST_EN defined: adds port out_last (out, 1). It is high together with out_valid on the final word of each row. Reset value 0. It is stored per buffer entry so it travels with its data.
- ROUTE_RD_LAST_EN undefined: the port does not exist and no per-entry flag is stored. All other behaviour is identical.

## Test plan
- rst, then start with row_words=4, row_num=2. Preload the FIFO with 8 words (0..7) and keep out_ready=1. Expect out_data 0..7 on 8 consecutive-per-row valid cycles, done exactly once after word 7, and 8 fifo_rd_en pulses total.
- fifo_ready held 0 for 20 cycles after start. Expect no fifo_rd_en and busy=1. Then raise fifo_ready; the first fifo_rd_en follows 1 cycle after it is sampled in WAIT.
- Backpressure: out_ready toggles 1,0,0,1 with row_words=6. Buffer occupancy and in-flight reads never exceed 2, and no words are lost or duplicated (sequence 0..5 intact).
- row_num=0 start: expect done pulse 1 cycle later, no fifo_rd_en, busy never asserted for more than 1 cycle.
- rst asserted mid-READ (after 3 of 8 reads). On the next cycle: out_valid=0, busy=0, fifo_rd_en=0. A new start with row_words=2 then runs cleanly.
- ROUTE_RD_LAST_EN defined, row_words=3, row_num=2: out_last is high only on words 2 and 5.
